// File: rtl/acc_sat_param.sv
// Framed signed accumulator with selectable saturating or wrap-around arithmetic.
// Collects LEN samples per frame, then holds the sum until the consumer accepts it.
module acc_sat_param #(
  parameter int WIDTH    = 16,
  parameter int IN_WIDTH = 16,
  parameter int LEN      = 8
) (
  input  logic                         acc_clk_i,
  input  logic                         acc_nreset_i,
  input  logic                         clear_i,
  input  logic                         sat_en_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [IN_WIDTH-1:0]          data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [WIDTH-1:0]             result_o,
  output logic                         ovf_o,
  output logic [$clog2(LEN+1)-1:0]     count_o
);

  localparam int CW = $clog2(LEN+1);
  localparam logic [CW-1:0] LAST = CW'(LEN-1);

  typedef enum logic {ACCUM, HOLD} state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;

  logic            accept;
  logic [WIDTH:0]  sum;
  logic            sum_ovf;
  logic [WIDTH-1:0] sum_fixed;

  assign accept = in_valid_i && (state_q == ACCUM) && !clear_i;

  // Overflow iff the two top bits of the WIDTH+1-bit sum disagree; the top bit gives the clamp direction.
  always_comb begin
    sum       = {acc_q[WIDTH-1], acc_q}
              + {{(WIDTH+1-IN_WIDTH){data_i[IN_WIDTH-1]}}, data_i};
    sum_ovf   = sum[WIDTH] ^ sum[WIDTH-1];
    sum_fixed = sum[WIDTH-1:0];
    if (sum_ovf && sat_en_i) begin
      sum_fixed = {sum[WIDTH], {(WIDTH-1){~sum[WIDTH]}}};
    end
  end

  always_ff @(posedge acc_clk_i or negedge acc_nreset_i) begin
    if (!acc_nreset_i) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = ACCUM;
    end else begin
      case (state_q)
        ACCUM:   if (accept && count_q == LAST) state_d = HOLD;
        HOLD:    if (out_ready_i) state_d = ACCUM;
        default: state_d = ACCUM;
      endcase
    end
  end

  always_comb begin
    in_ready_o  = (state_q == ACCUM);
    out_valid_o = (state_q == HOLD);
  end

  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear_i || (state_q == HOLD && out_ready_i)) begin
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (accept) begin
      acc_d   = sum_fixed;
      count_d = count_q + CW'(1);
      ovf_d   = ovf_q | sum_ovf;
    end
  end

  always_ff @(posedge acc_clk_i or negedge acc_nreset_i) begin
    if (!acc_nreset_i) begin
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign result_o = acc_q;
  assign ovf_o    = ovf_q;
  assign count_o  = count_q;

endmodule

// File: tb/tb_acc_sat_param.sv
// Bench for acc_sat_param (WIDTH=16, IN_WIDTH=16, LEN=4): frame vectors, backpressure,
// clear, async reset and a few modelled random frames through a result scoreboard.
module tb_acc_sat_param;

  localparam int W  = 16;
  localparam int L  = 4;
  localparam int CW = $clog2(L+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear_i = 1'b0;
  logic          sat_en_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [W-1:0]  data_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [W-1:0]  result_o;
  logic          ovf_o;
  logic [CW-1:0] count_o;

  acc_sat_param #(.WIDTH(W), .IN_WIDTH(W), .LEN(L)) dut (
    .acc_clk_i   (clk),
    .acc_nreset_i(rst_n),
    .clear_i     (clear_i),
    .sat_en_i    (sat_en_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .data_i      (data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .ovf_o       (ovf_o),
    .count_o     (count_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][W-1:0] s;
    logic [3:0]        sat;
    logic [W-1:0]      res;
    logic              ovf;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] res;
    logic         ovf;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [W-1:0] a, b, c, d, input logic [3:0] sat,
                              input logic [W-1:0] res, input logic ovf);
    vec_t v;
    v.s[0] = a; v.s[1] = b; v.s[2] = c; v.s[3] = d;
    v.sat = sat; v.res = res; v.ovf = ovf;
    return v;
  endfunction

  // Independent reference in integer arithmetic.
  function automatic exp_t model(input vec_t v);
    exp_t e;
    int acc = 0;
    int s;
    e.ovf = 1'b0;
    for (int i = 0; i < L; i++) begin
      s = acc + int'($signed(v.s[i]));
      if (s > 32767 || s < -32768) begin
        e.ovf = 1'b1;
        if (v.sat[i]) s = (s > 0) ? 32767 : -32768;
        else          s = (s > 0) ? s - 65536 : s + 65536;
      end
      acc = s;
    end
    e.res = W'(acc);
    return e;
  endfunction

  task automatic run_frame(input vec_t v, input bit gaps, input int hold_cycles);
    exp_t e;
    int n;
    sb_q.push_back('{res: v.res, ovf: v.ovf});
    for (int i = 0; i < L; i++) begin
      data_i = v.s[i]; sat_en_i = v.sat[i]; in_valid_i = 1'b1;
      tick();
      in_valid_i = 1'b0;
      if (gaps && i < L-1) begin
        data_i = W'($urandom);
        tick();
      end
    end
    n = 0;
    while (!out_valid_o && n < 8) begin
      tick();
      n++;
    end
    chk("out_valid_after_frame", {31'd0, out_valid_o}, 32'd1);
    e = sb_q.pop_front();
    chk("result", {16'd0, result_o}, {16'd0, e.res});
    chk("ovf", {31'd0, ovf_o}, {31'd0, e.ovf});
    chk("count_full", {29'd0, count_o}, L);
    for (int h = 0; h < hold_cycles; h++) begin
      in_valid_i = 1'b1; data_i = 16'd5;
      tick();
      chk("hold_result", {16'd0, result_o}, {16'd0, e.res});
      chk("hold_count", {29'd0, count_o}, L);
      chk("hold_ovf", {31'd0, ovf_o}, {31'd0, e.ovf});
      chk("hold_in_ready", {31'd0, in_ready_o}, 32'd0);
    end
  endtask

  task automatic release_frame();
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    in_valid_i  = 1'b0;
    chk("release_valid", {31'd0, out_valid_o}, 32'd0);
    chk("release_result", {16'd0, result_o}, 32'd0);
    chk("release_count", {29'd0, count_o}, 32'd0);
    chk("release_ovf", {31'd0, ovf_o}, 32'd0);
  endtask

  vec_t vecs[6];
  vec_t rv;

  initial begin
    vecs[0] = mk(16'h7000, 16'h7000, 16'hFFFF, 16'h0000, 4'hF, 16'h7FFE, 1'b1);
    vecs[1] = mk(16'd1, 16'd2, 16'd3, 16'd4, 4'hF, 16'd10, 1'b0);
    vecs[2] = mk(16'h7000, 16'h7000, 16'hFFFF, 16'h0000, 4'h0, 16'hDFFF, 1'b1);
    vecs[3] = mk(16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 4'hF, 16'h8000, 1'b1);
    vecs[4] = mk(16'hFFFD, 16'hFFFD, 16'd2, 16'd1, 4'h0, 16'hFFFD, 1'b0);
    // sample 1 wraps (sat off), others saturating: sticky ovf, no clamp afterwards
    vecs[5] = mk(16'h7000, 16'h7000, 16'h7000, 16'h0000, 4'b1101, 16'h5000, 1'b1);

    #12;
    chk("reset_valid", {31'd0, out_valid_o}, 32'd0);
    chk("reset_ready", {31'd0, in_ready_o}, 32'd1);
    chk("reset_result", {16'd0, result_o}, 32'd0);
    chk("reset_count", {29'd0, count_o}, 32'd0);
    chk("reset_ovf", {31'd0, ovf_o}, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i], (i % 2) == 1, 0);
      release_frame();
    end

    // Backpressure: held result, stalled input not absorbed, next frame starts clean.
    run_frame(mk(16'd1, 16'd2, 16'd3, 16'd4, 4'hF, 16'd10, 1'b0), 1'b0, 3);
    in_valid_i = 1'b1; data_i = 16'd5;
    release_frame();
    run_frame(mk(16'd1, 16'd1, 16'd1, 16'd1, 4'hF, 16'd4, 1'b0), 1'b0, 0);
    release_frame();

    // Clear mid-frame drops the sample offered with it.
    in_valid_i = 1'b1; data_i = 16'd7; tick();
    data_i = 16'd9; tick();
    chk("pre_clear_count", {29'd0, count_o}, 32'd2);
    chk("pre_clear_result", {16'd0, result_o}, 32'd16);
    data_i = 16'd100; clear_i = 1'b1; tick();
    clear_i = 1'b0; in_valid_i = 1'b0;
    chk("clear_result", {16'd0, result_o}, 32'd0);
    chk("clear_count", {29'd0, count_o}, 32'd0);
    run_frame(mk(16'd1, 16'd1, 16'd1, 16'd1, 4'h0, 16'd4, 1'b0), 1'b0, 0);
    // Clear also wins over the output handshake.
    out_ready_i = 1'b1; clear_i = 1'b1; tick();
    out_ready_i = 1'b0; clear_i = 1'b0;
    chk("clear_hold_valid", {31'd0, out_valid_o}, 32'd0);
    chk("clear_hold_result", {16'd0, result_o}, 32'd0);

    // Asynchronous reset while holding a result.
    run_frame(mk(16'd1, 16'd2, 16'd3, 16'd4, 4'hF, 16'd10, 1'b0), 1'b0, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("async_valid", {31'd0, out_valid_o}, 32'd0);
    chk("async_result", {16'd0, result_o}, 32'd0);
    chk("async_ready", {31'd0, in_ready_o}, 32'd1);
    chk("async_count", {29'd0, count_o}, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_reset_valid", {31'd0, out_valid_o}, 32'd0);

    for (int r = 0; r < 5; r++) begin
      rv = mk(W'($urandom), W'($urandom), W'($urandom), W'($urandom),
              4'($urandom), '0, 1'b0);
      if (r == 0) begin
        rv.s[0] = 16'h6000; rv.s[1] = 16'h6000;
      end
      {rv.res, rv.ovf} = model(rv);
      run_frame(rv, r[0], 1);
      release_frame();
    end

    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/acc_sat_param.md
ACC_SAT_PARAM -- requirements
Module: acc_sat_param

Interface
REQ-001 SHALL have parameter WIDTH, default 16: accumulator and result width in bits, signed two's complement.
REQ-002 SHALL have parameter IN_WIDTH, default 16: input sample width, signed, with IN_WIDTH <= WIDTH.
REQ-003 SHALL have parameter LEN, default 8: samples per frame, LEN >= 1.
REQ-004 SHALL have port acc_clk_i, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port acc_nreset_i, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port clear_i, input, 1 bit: synchronous frame abort and clear.
REQ-007 SHALL have port sat_en_i, input, 1 bit: 1 = saturating arithmetic, 0 = wrap-around arithmetic.
REQ-008 SHALL have port in_valid_i, input, 1 bit: a sample is offered on data_i.
REQ-009 SHALL have port in_ready_o, output, 1 bit: the block can accept a sample.
REQ-010 SHALL have port data_i, input, IN_WIDTH bits: signed sample.
REQ-011 SHALL have port out_valid_o, output, 1 bit: result_o holds a completed frame sum.
REQ-012 SHALL have port out_ready_i, input, 1 bit: the consumer accepts the result.
REQ-013 SHALL have port result_o, output, WIDTH bits: the accumulator value.
REQ-014 SHALL have port ovf_o, output, 1 bit: sticky per-frame overflow flag.
REQ-015 SHALL have port count_o, output, $clog2(LEN+1) bits: samples accepted in the current frame.

Function
REQ-016 SHALL implement two states: ACCUM (in_ready_o=1, out_valid_o=0) and HOLD (in_ready_o=0, out_valid_o=1).
REQ-017 SHALL accept a sample only on a cycle where in_valid_i=1 and in_ready_o=1; data_i is ignored on all other cycles.
REQ-018 SHALL, on an accepted sample, sign-extend data_i to WIDTH+1 bits, add it to the accumulator, and increment count_o.
REQ-019 SHALL detect signed overflow when the WIDTH+1-bit sum falls outside the WIDTH-bit signed range.
REQ-020 SHALL, with sat_en_i=1, clamp an overflowing sum to 2^(WIDTH-1)-1 (positive) or -2^(WIDTH-1) (negative); the next addition continues from the clamped value.
REQ-021 SHALL, with sat_en_i=0, keep the low WIDTH bits of an overflowing sum (wrap-around).
REQ-022 SHALL set ovf_o on any overflow in either mode; ovf_o stays set until the frame is released, clear_i is asserted, or reset is asserted.
REQ-023 SHALL sample sat_en_i on each accepted sample, so the mode may change mid-frame.
REQ-024 SHALL move ACCUM->HOLD on the edge that accepts sample number LEN; result_o, out_valid_o and count_o=LEN update on that edge (latency one cycle from the last sample).
REQ-025 SHALL, in HOLD, keep result_o, ovf_o and count_o stable while out_ready_i=0, for any number of cycles.
REQ-026 SHALL, in HOLD with out_ready_i=1, return to ACCUM on that edge with accumulator=0, count_o=0 and ovf_o=0; no sample is accepted on that cycle.
REQ-027 SHALL, with clear_i=1, on that edge zero the accumulator, count_o and ovf_o and enter ACCUM; clear_i has priority over sample acceptance and over the output handshake, and any sample presented that cycle is dropped.
REQ-028 SHALL, in ACCUM, drive result_o with the running partial sum.
REQ-029 SHALL, with LEN=1, enter HOLD after every accepted sample.

Reset
REQ-030 SHALL, while acc_nreset_i=0, force immediately and asynchronously: state=ACCUM, accumulator/result_o=0, count_o=0, ovf_o=0, out_valid_o=0, in_ready_o=1.
REQ-031 SHALL drop a partially accumulated frame or a pending HOLD result when reset is asserted mid-operation, with no completion signalled.
REQ-032 SHALL resume normal operation on the first rising edge after acc_nreset_i is deasserted.

Verification (WIDTH=16, IN_WIDTH=16, LEN=4 unless stated)
REQ-033 SHALL cover basic frame: samples 1, 2, 3, 4 with out_ready_i=1 -> one cycle after the 4th sample out_valid_o=1, result_o=10, ovf_o=0, count_o=4; next cycle ACCUM with result_o=0.
REQ-034 SHALL cover saturation: sat_en_i=1, samples 0x7000, 0x7000, 0xFFFF, 0x0000 -> result_o=0x7FFE, ovf_o=1; the same stimulus with sat_en_i=0 -> result_o=0xDFFF, ovf_o=1.
REQ-035 SHALL cover negative clamp: sat_en_i=1, samples 0x8000, 0xFFFF, 0x0000, 0x0000 -> result_o=0x8000, ovf_o=1.
REQ-036 SHALL cover backpressure: frame complete with out_ready_i=0 for 3 cycles while in_valid_i=1 and data_i=5 -> result_o, ovf_o and count_o held, in_ready_o=0, no sample absorbed; the next frame starts from 0.
REQ-037 SHALL cover clear: clear_i pulsed after samples 7, 9 while sample 100 is offered -> result_o=0 and count_o=0 next cycle, 100 dropped; a following frame 1, 1, 1, 1 -> result_o=4.
REQ-038 SHALL cover async reset: acc_nreset_i low mid-cycle while in HOLD with result_o=10 -> out_valid_o=0 and result_o=0 before the next clock edge.
